seven_seg_scanner: RTL and testbench

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

---
 rtl/seven_seg_if.sv | 27 ++
 rtl/seven_seg_scanner.sv | 186 ++++++++++++++++++
 tb/tb_seven_seg_scanner.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_if.sv
// seven_seg_if -- bundle between a display client and seven_seg_scanner.
//   master (client): drives value, dp_in, blank, load; observes AN, CX,
//                    upd_pending, frame_done.
//   slave (scanner): the reverse.
// DIGITS must match the scanner's DIGITS parameter.
interface seven_seg_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   blank;
  logic                load;
  logic [DIGITS-1:0]   AN;
  logic [7:0]          CX;
  logic                upd_pending;
  logic                frame_done;

  modport master (
    output value, dp_in, blank, load,
    input  AN, CX, upd_pending, frame_done
  );

  modport slave (
    input  value, dp_in, blank, load,
    output AN, CX, upd_pending, frame_done
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner -- time-multiplexed driver for a common-anode
// seven-segment display of DIGITS digits.
//
// Each digit is selected for REFRESH_DIV clocks; the first BLANK_CYC clocks
// of every slot keep all anodes off to avoid ghosting. New data is taken
// through a pending register and copied to the displayed register only at
// the frame boundary, so one frame never mixes old and new data.
//
// Ports:
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    seven_seg_if slave modport:
//            value/dp_in/blank/load  data and capture strobe in
//            AN          anode enables, active-low, registered
//            CX          cathodes {a..g, dp}, active-low, registered
//            upd_pending pending register holds data not yet shown
//            frame_done  one-cycle pulse after the digit index wraps to 0
//
// Build option: define SEG_LZ_SUPPRESS_EN to blank leading zeros (digit 0
// is never suppressed, decimal points still light).
module seven_seg_scanner #(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  seven_seg_if.slave bus
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          cnt_wrap;
  logic          frame_wrap;

  logic [4*DIGITS-1:0] pend_value;
  logic [DIGITS-1:0]   pend_dp;
  logic [DIGITS-1:0]   pend_blank;
  logic [4*DIGITS-1:0] act_value;
  logic [DIGITS-1:0]   act_dp;
  logic [DIGITS-1:0]   act_blank;

  logic [DIGITS-1:0] lz;
  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic              cur_blank;
  logic              cur_lz;
  logic [DIGITS-1:0] an_next;
  logic [7:0]        cx_next;

  function automatic logic [6:0] seg_map(input logic [3:0] n);
    seg_map = 7'h7F;
    case (n)
      4'h0: seg_map = 7'h01;
      4'h1: seg_map = 7'h4F;
      4'h2: seg_map = 7'h12;
      4'h3: seg_map = 7'h06;
      4'h4: seg_map = 7'h4C;
      4'h5: seg_map = 7'h24;
      4'h6: seg_map = 7'h20;
      4'h7: seg_map = 7'h0F;
      4'h8: seg_map = 7'h00;
      4'h9: seg_map = 7'h04;
      4'hA: seg_map = 7'h08;
      4'hB: seg_map = 7'h60;
      4'hC: seg_map = 7'h31;
      4'hD: seg_map = 7'h42;
      4'hE: seg_map = 7'h30;
      4'hF: seg_map = 7'h38;
      default: seg_map = 7'h7F;
    endcase
  endfunction

  assign cnt_wrap   = (cnt == CNT_LAST);
  assign frame_wrap = cnt_wrap && (idx == IDX_LAST);

  // Scan timebase: cnt within a slot, idx selects the digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      idx            <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= frame_wrap;
      if (cnt_wrap) begin
        cnt <= '0;
        if (idx == IDX_LAST) idx <= '0;
        else                 idx <= idx + IW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Pending/active double buffer. A load landing on the frame edge bypasses
  // pending so the new value is shown in the frame that starts right away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_value      <= '0;
      pend_dp         <= '0;
      pend_blank      <= '0;
      act_value       <= '0;
      act_dp          <= '0;
      act_blank       <= '0;
      bus.upd_pending <= 1'b0;
    end else begin
      if (bus.load) begin
        pend_value <= bus.value;
        pend_dp    <= bus.dp_in;
        pend_blank <= bus.blank;
      end
      if (frame_wrap && bus.load) begin
        act_value       <= bus.value;
        act_dp          <= bus.dp_in;
        act_blank       <= bus.blank;
        bus.upd_pending <= 1'b0;
      end else if (frame_wrap && bus.upd_pending) begin
        act_value       <= pend_value;
        act_dp          <= pend_dp;
        act_blank       <= pend_blank;
        bus.upd_pending <= 1'b0;
      end else if (bus.load) begin
        bus.upd_pending <= 1'b1;
      end
    end
  end

`ifdef SEG_LZ_SUPPRESS_EN
  // lz[i] is set when nibble i and every higher nibble are zero.
  logic lz_run;
  always_comb begin
    lz     = '0;
    lz_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz_run = lz_run && (act_value[4*i +: 4] == 4'h0);
      lz[i]  = lz_run;
    end
  end
`else
  assign lz = '0;
`endif

  // Select the current digit's data with an explicit compare so a
  // non-power-of-two DIGITS never indexes past the arrays.
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_lz    = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib   = act_value[4*i +: 4];
        cur_dp    = act_dp[i];
        cur_blank = act_blank[i];
        cur_lz    = lz[i];
      end
    end
  end

  always_comb begin
    an_next = '1;
    if (cnt >= CNT_BLANK) an_next = ~(DIGITS'(1) << idx);

    if (cur_blank)   cx_next = 8'hFF;
    else if (cur_lz) cx_next = {7'h7F, ~cur_dp};
    else             cx_next = {seg_map(cur_nib), ~cur_dp};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.AN <= '1;
      bus.CX <= 8'hFF;
    end else begin
      bus.AN <= an_next;
      bus.CX <= cx_next;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
module tb_seven_seg_scanner;

  localparam int D = 4;

  logic clk;
  logic rst_n;

  seven_seg_if #(.DIGITS(D)) bus ();

  seven_seg_scanner #(
    .DIGITS     (D),
    .REFRESH_DIV(8),
    .BLANK_CYC  (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic [3:0]      blank;
    logic [3:0][7:0] exp;   // exp[d] = CX shown on digit d
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance to the negedge where frame_done is high, with a bound.
  task automatic wait_frame(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (bus.frame_done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " frame_done_seen"}, 32'(bus.frame_done), 32'd1);
  endtask

  // Entered at the negedge right after the frame edge (cnt=0, idx=0).
  task automatic check_frame(input logic [3:0][7:0] exp, input string tag);
    logic [3:0] an_e;
    repeat (2) @(negedge clk);
    chk({tag, " slot_blank_an"}, 32'(bus.AN), 32'hF);
    for (int d = 0; d < D; d++) begin
      if (d == 0) @(negedge clk);
      else repeat (8) @(negedge clk);
      an_e = ~(4'b0001 << d);
      chk($sformatf("%s an_d%0d", tag, d), 32'(bus.AN), 32'(an_e));
      chk($sformatf("%s cx_d%0d", tag, d), 32'(bus.CX), 32'(exp[d]));
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    bus.value = v;
    bus.dp_in = dp;
    bus.blank = bl;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
  endtask

  logic [3:0][7:0] zero_frame;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] an_e;
    logic [7:0] cx_e;
    int c, ix;

`ifdef SEG_LZ_SUPPRESS_EN
    zero_frame = {8'hFF, 8'hFF, 8'hFF, 8'h03};
`else
    zero_frame = {8'h03, 8'h03, 8'h03, 8'h03};
`endif

    vecs[0] = '{16'h12AF, 4'b0100, 4'b0000, {8'h9F, 8'h24, 8'h11, 8'h71}};
    vecs[1] = '{16'h8888, 4'b0000, 4'b1000, {8'hFF, 8'h01, 8'h01, 8'h01}};
    vecs[3] = '{16'h3456, 4'b1111, 4'b0000, {8'h0C, 8'h98, 8'h48, 8'h40}};
    vecs[4] = '{16'h7BCD, 4'b0000, 4'b0000, {8'h1F, 8'hC1, 8'h63, 8'h85}};
    vecs[5] = '{16'hE9E9, 4'b1000, 4'b0101, {8'h60, 8'hFF, 8'h61, 8'hFF}};
`ifdef SEG_LZ_SUPPRESS_EN
    vecs[2] = '{16'h0040, 4'b0000, 4'b0000, {8'hFF, 8'hFF, 8'h99, 8'h03}};
    vecs[6] = '{16'h0001, 4'b0001, 4'b0001, {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
    vecs[7] = '{16'h0005, 4'b0010, 4'b0000, {8'hFF, 8'hFF, 8'hFE, 8'h49}};
    vecs[8] = '{16'h0000, 4'b0000, 4'b0000, {8'hFF, 8'hFF, 8'hFF, 8'h03}};
`else
    vecs[2] = '{16'h0040, 4'b0000, 4'b0000, {8'h03, 8'h03, 8'h99, 8'h03}};
    vecs[6] = '{16'h0001, 4'b0001, 4'b0001, {8'h03, 8'h03, 8'h03, 8'hFF}};
    vecs[7] = '{16'h0005, 4'b0010, 4'b0000, {8'h03, 8'h03, 8'h02, 8'h49}};
    vecs[8] = '{16'h0000, 4'b0000, 4'b0000, {8'h03, 8'h03, 8'h03, 8'h03}};
`endif

    bus.value = '0;
    bus.dp_in = '0;
    bus.blank = '0;
    bus.load  = 1'b0;
    rst_n     = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset an", 32'(bus.AN), 32'hF);
    chk("reset cx", 32'(bus.CX), 32'hFF);
    chk("reset upd_pending", 32'(bus.upd_pending), 32'd0);
    chk("reset frame_done", 32'(bus.frame_done), 32'd0);
    rst_n = 1'b1;

    // Free-running scan after reset: state before edge n is cnt=(n-1)%8,
    // idx=((n-1)/8)%4; outputs reflect it after edge n.
    for (int n = 1; n <= 70; n++) begin
      @(negedge clk);
      c  = (n - 1) % 8;
      ix = ((n - 1) / 8) % 4;
      an_e = (c < 2) ? 4'hF : ~(4'b0001 << ix);
      cx_e = zero_frame[ix];
      chk($sformatf("scan an n=%0d", n), 32'(bus.AN), 32'(an_e));
      chk($sformatf("scan cx n=%0d", n), 32'(bus.CX), 32'(cx_e));
      chk($sformatf("scan frame_done n=%0d", n), 32'(bus.frame_done), 32'((n % 32) == 0));
    end

    // Table-driven: load mid-frame, expect it in the next frame only.
    for (int v = 0; v < NV; v++) begin
      wait_frame($sformatf("vec%0d", v));
      repeat (5) @(negedge clk);
      do_load(vecs[v].value, vecs[v].dp, vecs[v].blank);
      chk($sformatf("vec%0d upd_pending set", v), 32'(bus.upd_pending), 32'd1);
      wait_frame($sformatf("vec%0d", v));
      chk($sformatf("vec%0d upd_pending cleared", v), 32'(bus.upd_pending), 32'd0);
      check_frame(vecs[v].exp, $sformatf("vec%0d", v));
    end

    // Two loads in one frame: only the later one is shown.
    wait_frame("twoload");
    repeat (3) @(negedge clk);
    do_load(16'h1111, 4'b0000, 4'b0000);
    repeat (5) @(negedge clk);
    do_load(16'h2222, 4'b0000, 4'b0000);
    chk("twoload upd_pending set", 32'(bus.upd_pending), 32'd1);
    wait_frame("twoload");
    chk("twoload upd_pending cleared", 32'(bus.upd_pending), 32'd0);
    check_frame({8'h25, 8'h25, 8'h25, 8'h25}, "twoload");

    // Load in the same cycle as the frame wrap: shown at once, never pending.
    wait_frame("coinc");
    repeat (31) @(negedge clk);
    chk("coinc upd_pending before", 32'(bus.upd_pending), 32'd0);
    do_load(16'h5A5A, 4'b0000, 4'b0000);
    chk("coinc frame_done", 32'(bus.frame_done), 32'd1);
    chk("coinc upd_pending", 32'(bus.upd_pending), 32'd0);
    check_frame({8'h49, 8'h11, 8'h49, 8'h11}, "coinc");

    // Reset mid-slot with data pending: outputs forced immediately,
    // pending discarded, scan restarts at digit 0.
    wait_frame("rst");
    repeat (10) @(negedge clk);
    do_load(16'h7777, 4'b0000, 4'b0000);
    chk("rst upd_pending before", 32'(bus.upd_pending), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst async an", 32'(bus.AN), 32'hF);
    chk("rst async cx", 32'(bus.CX), 32'hFF);
    chk("rst async upd_pending", 32'(bus.upd_pending), 32'd0);
    chk("rst async frame_done", 32'(bus.frame_done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst restart blank an", 32'(bus.AN), 32'hF);
    @(negedge clk);
    chk("rst restart an_d0", 32'(bus.AN), 32'hE);
    chk("rst restart cx_d0", 32'(bus.CX), 32'(zero_frame[0]));
    chk("rst restart upd_pending", 32'(bus.upd_pending), 32'd0);
    wait_frame("rst");
    chk("rst no stale update", 32'(bus.upd_pending), 32'd0);
    check_frame(zero_frame, "rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
